// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data memory responder: access sizes, MMIO offsets,
// status bit positions, clear-FSM states and the size/alignment helper.
// Pure declarations; no logic, no latency, no flow control.
package data_mem_responder_pkg;

  localparam int EXT_MEM_CWIDTH = 2;

  // Access size encodings carried on iMemDataType
  localparam logic [EXT_MEM_CWIDTH-1:0] EXT_MEM_WORD = 2'd0;
  localparam logic [EXT_MEM_CWIDTH-1:0] EXT_MEM_HALF = 2'd1;
  localparam logic [EXT_MEM_CWIDTH-1:0] EXT_MEM_BYTE = 2'd2;

  // MMIO register selects, taken from addr[3:2] inside the 16-byte block
  localparam logic [1:0] MMIO_OFF_CYCLE  = 2'd0;
  localparam logic [1:0] MMIO_OFF_CMP    = 2'd1;
  localparam logic [1:0] MMIO_OFF_STATUS = 2'd2;
  localparam logic [1:0] MMIO_OFF_RSVD   = 2'd3;

  // STATUS bit positions
  localparam int STAT_MISALIGN = 0;
  localparam int STAT_IRQ      = 1;
  localparam int STAT_UNMAPPED = 2;
  localparam int STAT_W        = 3;

  // Power-up clear sequencer states
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_e;

  // Natural-alignment rule for RAM/unmapped accesses
  function automatic logic size_misaligned(input logic [EXT_MEM_CWIDTH-1:0] dtype,
                                           input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (dtype)
      EXT_MEM_WORD: mis = (lo != 2'b00);
      EXT_MEM_HALF: mis = lo[0];
      default:      mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_mem_responder_mmio_timer.sv
// MMIO block: free-running CYCLE counter, CMP register and sticky STATUS (W1C).
// Reads are combinational; writes and status events land on the next edge.
// No backpressure: every access completes in the cycle it is presented.
module data_mem_responder_mmio_timer
  import data_mem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cnt_en,
  input  logic        misalign_evt,
  input  logic        unmapped_evt,
  input  logic        mmio_we,
  input  logic [1:0]  mmio_off,
  input  logic [31:0] mmio_wdat,
  output logic [31:0] mmio_rdat,
  output logic        irq
);

  logic [31:0]       cycle_q, cycle_d;
  logic [31:0]       cmp_q, cmp_d;
  logic [STAT_W-1:0] status_q, status_d;
  logic [STAT_W-1:0] stat_set, stat_clr;
  logic              cmp_match;

  // Counter/compare update and sticky status; a set event beats a same-cycle clear
  always_comb begin
    cycle_d  = cnt_en ? cycle_q + 32'd1 : cycle_q;
    cmp_d    = cmp_q;
    stat_clr = '0;
    if (mmio_we) begin
      case (mmio_off)
        MMIO_OFF_CMP:    cmp_d    = mmio_wdat;
        MMIO_OFF_STATUS: stat_clr = mmio_wdat[STAT_W-1:0];
        default:         ;
      endcase
    end
    cmp_match = (cycle_q == cmp_q) && (cmp_q != 32'd0);
    stat_set                = '0;
    stat_set[STAT_MISALIGN] = misalign_evt;
    stat_set[STAT_IRQ]      = cmp_match;
    stat_set[STAT_UNMAPPED] = unmapped_evt;
    status_d = (status_q & ~stat_clr) | stat_set;
  end

  // Register state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q  <= '0;
      cmp_q    <= '0;
      status_q <= '0;
    end else begin
      cycle_q  <= cycle_d;
      cmp_q    <= cmp_d;
      status_q <= status_d;
    end
  end

  // Combinational register read-back
  always_comb begin
    mmio_rdat = 32'd0;
    case (mmio_off)
      MMIO_OFF_CYCLE:  mmio_rdat = cycle_q;
      MMIO_OFF_CMP:    mmio_rdat = cmp_q;
      MMIO_OFF_STATUS: mmio_rdat = {{(32-STAT_W){1'b0}}, status_q};
      default:         mmio_rdat = 32'd0;
    endcase
  end

  assign irq = status_q[STAT_IRQ];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: word RAM with byte lanes, power-up clear, MMIO timer.
// Reads are combinational (same cycle); writes commit on the next rising edge.
// No backpressure; accesses during the clear sequence are ignored and read 0.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] RAM_BASE    = 32'h1001_0000,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      iMemR,
  input  logic                      iMemW,
  input  logic [EXT_MEM_CWIDTH-1:0] iMemDataType,
  input  logic [31:0]               iMemAddr,
  input  logic [31:0]               iMemData,
  output logic [31:0]               oMemData,
  output logic                      oReady,
  output logic                      oMisalign,
  output logic                      oIrq
);

  localparam int          IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_END = {1'b0, RAM_BASE} + 33'(DEPTH_WORDS * 4);

  clr_state_e       state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             ready, clr_we;
  logic             misalign_q, misalign_d;

  logic [31:0]      mem [DEPTH_WORDS];

  logic             ram_hit, mmio_hit, access, mis;
  logic             misalign_evt, unmapped_evt, mmio_we;
  logic [IDX_W-1:0] ram_idx;
  logic [31:0]      ram_word, ram_rdat, ram_wdat, mmio_rdat;
  logic             mem_we;
  logic [IDX_W-1:0] mem_widx;
  logic [31:0]      mem_wdat;

  // Clear FSM state register and clear pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Clear FSM next state: walk every word once, then hold READY until reset
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == ST_CLEAR) begin
      clr_idx_d = clr_idx_q + IDX_W'(1);
      if (clr_idx_q == IDX_W'(DEPTH_WORDS - 1)) begin
        state_d = ST_READY;
      end
    end
  end

  // Clear FSM outputs
  always_comb begin
    ready  = (state_q == ST_READY);
    clr_we = (state_q == ST_CLEAR);
  end

  // Address decode, alignment check and event generation
  always_comb begin
    ram_hit  = ({1'b0, iMemAddr} >= {1'b0, RAM_BASE}) && ({1'b0, iMemAddr} < RAM_END);
    mmio_hit = (iMemAddr[31:4] == MMIO_BASE[31:4]);
    ram_idx  = IDX_W'((iMemAddr - RAM_BASE) >> 2);
    access   = iMemR | iMemW;
    // MMIO registers only accept aligned word accesses
    if (mmio_hit) begin
      mis = (iMemDataType != EXT_MEM_WORD) || (iMemAddr[1:0] != 2'b00);
    end else begin
      mis = size_misaligned(iMemDataType, iMemAddr[1:0]);
    end
    misalign_evt = ready & access & mis;
    unmapped_evt = ready & access & ~ram_hit & ~mmio_hit;
    mmio_we      = ready & iMemW & mmio_hit & ~mis;
  end

  // Little-endian lane extraction for loads and lane merge for stores
  always_comb begin
    ram_word = mem[ram_idx];
    ram_rdat = ram_word;
    ram_wdat = ram_word;
    case (iMemDataType)
      EXT_MEM_BYTE: begin
        ram_rdat = {24'b0, ram_word[{iMemAddr[1:0], 3'b000} +: 8]};
        ram_wdat[{iMemAddr[1:0], 3'b000} +: 8] = iMemData[7:0];
      end
      EXT_MEM_HALF: begin
        ram_rdat = {16'b0, ram_word[{iMemAddr[1], 4'b0000} +: 16]};
        ram_wdat[{iMemAddr[1], 4'b0000} +: 16] = iMemData[15:0];
      end
      default: begin
        ram_rdat = ram_word;
        ram_wdat = iMemData;
      end
    endcase
  end

  // Load data mux; zero when not reading, clearing, misaligned or unmapped
  always_comb begin
    oMemData = 32'd0;
    if (iMemR && ready && !mis) begin
      if (ram_hit) begin
        oMemData = ram_rdat;
      end else if (mmio_hit) begin
        oMemData = mmio_rdat;
      end
    end
  end

  // RAM write port: the clear sequence owns it until READY
  always_comb begin
    mem_we   = 1'b0;
    mem_widx = ram_idx;
    mem_wdat = ram_wdat;
    if (clr_we) begin
      mem_we   = 1'b1;
      mem_widx = clr_idx_q;
      mem_wdat = 32'd0;
    end else if (ready && iMemW && ram_hit && !mis) begin
      mem_we = 1'b1;
    end
  end

  // RAM array (contents initialised by the clear sequence, not by reset)
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdat;
    end
  end

  // One-cycle misalign pulse
  always_comb begin
    misalign_d = misalign_evt;
  end

  // Misalign pulse register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  data_mem_responder_mmio_timer u_mmio_timer (
    .clk          (clk),
    .rst          (rst),
    .cnt_en       (ready),
    .misalign_evt (misalign_evt),
    .unmapped_evt (unmapped_evt),
    .mmio_we      (mmio_we),
    .mmio_off     (iMemAddr[3:2]),
    .mmio_wdat    (iMemData),
    .mmio_rdat    (mmio_rdat),
    .irq          (oIrq)
  );

  assign oReady    = ready;
  assign oMisalign = misalign_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus random
// accesses compared against a behavioural memory/MMIO model.
module tb_data_mem_responder;

  localparam logic [31:0] RB = 32'h1001_0000;
  localparam logic [31:0] MB = 32'hFFFF_0000;
  localparam int          DW = 1024;
  localparam logic [1:0]  T_WORD = 2'd0;
  localparam logic [1:0]  T_HALF = 2'd1;
  localparam logic [1:0]  T_BYTE = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iMemR = 1'b0;
  logic        iMemW = 1'b0;
  logic [1:0]  iMemDataType = 2'd0;
  logic [31:0] iMemAddr = 32'd0;
  logic [31:0] iMemData = 32'd0;
  logic [31:0] oMemData;
  logic        oReady, oMisalign, oIrq;

  data_mem_responder dut (
    .clk          (clk),
    .rst          (rst),
    .iMemR        (iMemR),
    .iMemW        (iMemW),
    .iMemDataType (iMemDataType),
    .iMemAddr     (iMemAddr),
    .iMemData     (iMemData),
    .oMemData     (oMemData),
    .oReady       (oReady),
    .oMisalign    (oMisalign),
    .oIrq         (oIrq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_ram [DW];
  logic [31:0] m_cycle, m_cmp;
  logic [2:0]  m_status;
  logic        m_mis;
  int          m_edges;
  bit          m_ready;

  task automatic m_reset();
    for (int i = 0; i < DW; i++) m_ram[i] = 32'd0;
    m_cycle = 0; m_cmp = 0; m_status = 0; m_mis = 0;
    m_edges = 0; m_ready = 0;
  endtask

  function automatic bit f_ram(input logic [31:0] a);
    return (a >= RB) && ((a - RB) < 32'(4 * DW));
  endfunction

  function automatic bit f_mmio(input logic [31:0] a);
    return (a & 32'hFFFF_FFF0) == MB;
  endfunction

  function automatic bit f_mis(input logic [1:0] t, input logic [31:0] a);
    if (f_mmio(a)) return (t != T_WORD) || (a[1:0] != 2'b00);
    if (t == T_WORD) return a[1:0] != 2'b00;
    if (t == T_HALF) return a[0];
    return 1'b0;
  endfunction

  function automatic logic [31:0] f_read(input logic [1:0] t, input logic [31:0] a);
    logic [31:0] w;
    if (!m_ready || f_mis(t, a)) return 32'd0;
    if (f_ram(a)) begin
      w = m_ram[(a - RB) >> 2];
      if (t == T_BYTE) return (w >> (8 * a[1:0])) & 32'hFF;
      if (t == T_HALF) return (w >> (16 * a[1])) & 32'hFFFF;
      return w;
    end
    if (f_mmio(a)) begin
      case (a[3:2])
        2'd0:    return m_cycle;
        2'd1:    return m_cmp;
        2'd2:    return {29'd0, m_status};
        default: return 32'd0;
      endcase
    end
    return 32'd0;
  endfunction

  // Advance the model by one rising edge given the access presented before it
  task automatic m_step(input bit r, input bit w, input logic [1:0] t,
                        input logic [31:0] a, input logic [31:0] d);
    logic [2:0]  set, clr;
    logic [31:0] word, mask;
    int          idx;
    set = 0; clr = 0;
    if (m_ready && (r || w) && f_mis(t, a)) set[0] = 1;
    if (m_ready && (r || w) && !f_ram(a) && !f_mmio(a)) set[2] = 1;
    if (m_cycle == m_cmp && m_cmp != 0) set[1] = 1;
    if (m_ready && w && !f_mis(t, a)) begin
      if (f_ram(a)) begin
        idx  = int'((a - RB) >> 2);
        word = m_ram[idx];
        if (t == T_BYTE) begin
          mask = 32'hFF << (8 * a[1:0]);
          word = (word & ~mask) | ((d & 32'hFF) << (8 * a[1:0]));
        end else if (t == T_HALF) begin
          mask = 32'hFFFF << (16 * a[1]);
          word = (word & ~mask) | ((d & 32'hFFFF) << (16 * a[1]));
        end else begin
          word = d;
        end
        m_ram[idx] = word;
      end else if (f_mmio(a)) begin
        if (a[3:2] == 2'd1) m_cmp = d;
        if (a[3:2] == 2'd2) clr = d[2:0];
      end
    end
    m_status = (m_status & ~clr) | set;
    m_mis    = set[0];
    if (m_ready) m_cycle = m_cycle + 1;
    m_edges++;
    if (m_edges >= DW) m_ready = 1;
  endtask

  // One bus cycle: drive, check load data mid-cycle, step model, check registered outputs
  task automatic do_cycle(input bit r, input bit w, input logic [1:0] t,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
    iMemR = r; iMemW = w; iMemDataType = t; iMemAddr = a; iMemData = d;
    @(negedge clk);
    rd = oMemData;
    check_val("rdata", oMemData, r ? f_read(t, a) : 32'd0);
    @(posedge clk);
    m_step(r, w, t, a, d);
    #1;
    check_val("misalign", {31'd0, oMisalign}, {31'd0, m_mis});
    check_val("irq", {31'd0, oIrq}, {31'd0, m_status[1]});
    check_val("ready", {31'd0, oReady}, {31'd0, m_ready});
    iMemR = 0; iMemW = 0;
  endtask

  task automatic idle(input int n);
    logic [31:0] junk;
    for (int i = 0; i < n; i++) do_cycle(0, 0, T_WORD, 32'd0, 32'd0, junk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] a, d, target;
    logic [1:0]  t;
    bit          r, w, got;
    int          sel;

    m_reset();
    // Reset state
    iMemR = 1; iMemAddr = RB; iMemDataType = T_WORD;
    #12;
    check_val("rst_ready", {31'd0, oReady}, 32'd0);
    check_val("rst_misalign", {31'd0, oMisalign}, 32'd0);
    check_val("rst_irq", {31'd0, oIrq}, 32'd0);
    check_val("rst_rdata", oMemData, 32'd0);
    iMemR = 0;
    @(posedge clk); #1; rst = 1;

    // Clear sequence length
    for (int i = 0; i < DW; i++) begin
      idle(1);
      if (i == DW - 2) check_val("ready_before_1024", {31'd0, oReady}, 32'd0);
    end
    check_val("ready_at_1024", {31'd0, oReady}, 32'd1);

    do_cycle(1, 0, T_WORD, RB, 0, rd);
    check_val("ram0_cleared", rd, 32'd0);
    do_cycle(0, 1, T_WORD, MB + 4, 32'd100, rd);

    // Lane tests
    do_cycle(0, 1, T_WORD, RB + 4, 32'hA1B2_C3D4, rd);
    do_cycle(1, 0, T_BYTE, RB + 5, 0, rd);
    check_val("lb_5", rd, 32'h0000_00C3);
    do_cycle(1, 0, T_HALF, RB + 6, 0, rd);
    check_val("lh_6", rd, 32'h0000_A1B2);
    do_cycle(0, 1, T_BYTE, RB + 7, 32'h0000_0055, rd);
    do_cycle(1, 0, T_WORD, RB + 4, 0, rd);
    check_val("lw_after_sb", rd, 32'h55B2_C3D4);

    // Misaligned accesses
    do_cycle(1, 0, T_HALF, RB + 1, 0, rd);
    check_val("lh_mis_data", rd, 32'd0);
    check_val("lh_mis_pulse", {31'd0, oMisalign}, 32'd1);
    idle(1);
    check_val("mis_pulse_end", {31'd0, oMisalign}, 32'd0);
    do_cycle(0, 1, T_WORD, RB + 2, 32'hDEAD_BEEF, rd);
    check_val("sw_mis_pulse", {31'd0, oMisalign}, 32'd1);
    do_cycle(1, 0, T_WORD, RB, 0, rd);
    check_val("ram0_unchanged", rd, 32'd0);
    do_cycle(1, 0, T_WORD, MB + 8, 0, rd);
    check_val("status_mis", rd, 32'd1);
    do_cycle(0, 1, T_WORD, MB + 8, 32'd1, rd);
    do_cycle(1, 0, T_WORD, MB + 8, 0, rd);
    check_val("status_cleared", rd, 32'd0);

    // Timer compare at 100
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      idle(1);
      if (oIrq) got = 1;
    end
    check_val("irq_rose", {31'd0, got}, 32'd1);
    do_cycle(1, 0, T_WORD, MB, 0, rd);
    check_val("cycle_after_irq", rd, 32'd101);

    // Unmapped access
    do_cycle(0, 1, T_WORD, MB + 8, 32'd7, rd);
    do_cycle(0, 1, T_WORD, 32'h2000_0000, 32'h1234_5678, rd);
    do_cycle(1, 0, T_WORD, 32'h2000_0000, 0, rd);
    check_val("unmapped_rd", rd, 32'd0);
    do_cycle(1, 0, T_WORD, MB + 8, 0, rd);
    check_val("status_unmapped", rd, 32'd4);

    // Set wins over same-cycle clear
    do_cycle(0, 1, T_WORD, MB + 8, 32'd7, rd);
    target = m_cycle + 20;
    do_cycle(0, 1, T_WORD, MB + 4, target, rd);
    for (int i = 0; i < 100 && m_cycle != target; i++) idle(1);
    do_cycle(0, 1, T_WORD, MB + 8, 32'd2, rd);
    check_val("irq_set_wins", {31'd0, oIrq}, 32'd1);

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      sel = $urandom_range(0, 9);
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      t = 2'($urandom_range(0, 2));
      d = $urandom;
      case (sel)
        5:       a = RB + 32'(4 * DW) - 32'd16 + 32'($urandom_range(0, 19));
        6, 7: begin
          a = MB + 32'($urandom_range(0, 3) << 2);
          if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(0, 3));
          if ($urandom_range(0, 1) == 1) t = T_WORD;
          if (a[3:2] == 2'd1 && $urandom_range(0, 1) == 1) d = m_cycle + 32'($urandom_range(1, 6));
        end
        8:       a = $urandom;
        9:       a = RB - 32'($urandom_range(1, 4));
        default: a = RB + 32'($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3));
      endcase
      do_cycle(r, w, t, a, d, rd);
    end

    // Reset in the middle of the clear sequence
    rst = 0;
    #1;
    check_val("rst2_ready", {31'd0, oReady}, 32'd0);
    check_val("rst2_irq", {31'd0, oIrq}, 32'd0);
    @(posedge clk); #1; rst = 1;
    m_reset();
    idle(300);
    rst = 0;
    #1;
    check_val("rst3_ready", {31'd0, oReady}, 32'd0);
    check_val("rst3_misalign", {31'd0, oMisalign}, 32'd0);
    @(posedge clk); #1; rst = 1;
    m_reset();
    for (int i = 0; i < DW; i++) begin
      idle(1);
      if (i == DW - 2) check_val("ready2_before_1024", {31'd0, oReady}, 32'd0);
    end
    check_val("ready2_at_1024", {31'd0, oReady}, 32'd1);
    do_cycle(1, 0, T_WORD, RB + 4, 0, rd);
    check_val("ram1_recleared", rd, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
